// File: rtl/lru_pkg.sv
// Shared types and helpers for the LRU set array.
//   lru_rw(ways)      : rank width for a given associativity
//   lru_sw(sets)      : set-index width (at least 1 bit)
//   onehot_ok(vec)    : 1 when exactly one bit of vec is set
//   default_row(ways) : packed row with way k holding rank k
// Rows are packed way k at [k*RW +: RW]; helpers work on 16 ways x 4 bits max.
package lru_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_HIT  = 2'd1,
    OP_FILL = 2'd2,
    OP_INV  = 2'd3
  } lru_op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } lru_state_e;

  localparam int MAX_WAYS  = 16;
  localparam int MAX_RW    = 4;
  localparam int MAX_ROW_W = MAX_WAYS * MAX_RW;

  function automatic int lru_rw(input int ways);
    return $clog2(ways);
  endfunction

  function automatic int lru_sw(input int sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  // Zero and any vector with more than one bit set both fail.
  function automatic logic onehot_ok(input logic [MAX_WAYS-1:0] vec);
    return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
  endfunction

  function automatic logic [MAX_ROW_W-1:0] default_row(input int ways);
    logic [MAX_ROW_W-1:0] row;
    int rw;
    row = '0;
    rw  = lru_rw(ways);
    for (int k = 0; k < MAX_WAYS; k++) begin
      for (int b = 0; b < MAX_RW; b++) begin
        if (k < ways && b < rw) row[k*rw+b] = k[b];
      end
    end
    return row;
  endfunction

endpackage

// File: rtl/lru_rank_update.sv
// Combinational rank update for one set.
//   row_i    : current rank row (rank 0 = MRU, WAYS-1 = LRU)
//   op_i     : NONE / HIT / FILL / INV
//   way_i    : one-hot way for HIT and INV (ignored for FILL)
//   row_o    : row after the operation (row_i when NONE or on error)
//   victim_o : one-hot LRU way of row_o
//   err_o    : HIT/INV with a way vector that is not exactly one-hot
module lru_rank_update
  import lru_pkg::*;
#(
  parameter  int WAYS = 8,
  localparam int RW   = lru_rw(WAYS)
) (
  input  logic [WAYS*RW-1:0] row_i,
  input  lru_op_e            op_i,
  input  logic [WAYS-1:0]    way_i,
  output logic [WAYS*RW-1:0] row_o,
  output logic [WAYS-1:0]    victim_o,
  output logic               err_o
);

  localparam logic [RW-1:0] LRU_RANK = RW'(WAYS - 1);

  logic [WAYS-1:0] vic_cur;
  logic [WAYS-1:0] sel;
  logic [RW-1:0]   sel_rank;

  always_comb begin
    vic_cur  = '0;
    sel      = '0;
    sel_rank = '0;
    row_o    = row_i;
    victim_o = '0;
    err_o    = 1'b0;

    for (int k = 0; k < WAYS; k++) begin
      vic_cur[k] = (row_i[k*RW +: RW] == LRU_RANK);
    end

    // A fill behaves as a hit on the current victim, which is always one-hot
    // because every row is a permutation.
    sel   = (op_i == OP_FILL) ? vic_cur : way_i;
    err_o = ((op_i == OP_HIT) || (op_i == OP_INV)) &&
            !onehot_ok(MAX_WAYS'(way_i));

    for (int k = 0; k < WAYS; k++) begin
      if (sel[k]) sel_rank = sel_rank | row_i[k*RW +: RW];
    end

    if (!err_o) begin
      for (int k = 0; k < WAYS; k++) begin
        case (op_i)
          OP_HIT, OP_FILL: begin
            if (sel[k])
              row_o[k*RW +: RW] = '0;
            else if (row_i[k*RW +: RW] < sel_rank)
              row_o[k*RW +: RW] = row_i[k*RW +: RW] + 1'b1;
          end
          OP_INV: begin
            if (sel[k])
              row_o[k*RW +: RW] = LRU_RANK;
            else if (row_i[k*RW +: RW] > sel_rank)
              row_o[k*RW +: RW] = row_i[k*RW +: RW] - 1'b1;
          end
          default: ;
        endcase
      end
    end

    for (int k = 0; k < WAYS; k++) begin
      victim_o[k] = (row_o[k*RW +: RW] == LRU_RANK);
    end
  end

endmodule

// File: rtl/lru_set_array.sv
// True-LRU replacement state for a set-associative cache.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   i_set_idx           : set addressed by this cycle's op and lookup
//   i_lru_write_enable  : global enable for any state change
//   i_hit_sig/i_hit_way : hit update, one-hot way
//   i_fill_sig          : promote the addressed set's victim to MRU
//   i_inv_sig/i_inv_way : demote a one-hot way to LRU
//   o_ready             : init sweep finished; requests ignored while low
//   o_victim_way        : registered one-hot LRU way of the addressed set
//   o_victim_valid      : o_ready was high in the lookup cycle
//   o_rank              : registered rank row of the addressed set
//   o_err               : one-cycle pulse for an accepted non-one-hot way
// Request handshake: a request is taken in a cycle iff o_ready and
// i_lru_write_enable are high and any op strobe is high; there is no
// backpressure beyond o_ready. Priority inv > hit > fill; losers are dropped.
module lru_set_array
  import lru_pkg::*;
#(
  parameter  int WAYS = 8,
  parameter  int SETS = 16,
  localparam int RW   = lru_rw(WAYS),
  localparam int SW   = lru_sw(SETS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SW-1:0]      i_set_idx,
  input  logic               i_lru_write_enable,
  input  logic               i_hit_sig,
  input  logic [WAYS-1:0]    i_hit_way,
  input  logic               i_fill_sig,
  input  logic               i_inv_sig,
  input  logic [WAYS-1:0]    i_inv_way,
  output logic               o_ready,
  output logic [WAYS-1:0]    o_victim_way,
  output logic               o_victim_valid,
  output logic [WAYS*RW-1:0] o_rank,
  output logic               o_err
);

  localparam int                   ROW_W    = WAYS * RW;
  localparam logic [MAX_ROW_W-1:0] DEF_FULL = default_row(WAYS);
  localparam logic [ROW_W-1:0]     DEF_ROW  = DEF_FULL[ROW_W-1:0];
  localparam logic [WAYS-1:0]      DEF_VIC  = {1'b1, {(WAYS-1){1'b0}}};

  lru_state_e       state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [ROW_W-1:0] mem_q [SETS];

  logic             ready;
  logic [ROW_W-1:0] cur_row, upd_row;
  lru_op_e          op;
  logic [WAYS-1:0]  op_way, upd_victim;
  logic             upd_err;
  logic             init_hit;

  logic [ROW_W-1:0] rank_q, rank_d;
  logic [WAYS-1:0]  victim_q, victim_d;
  logic             valid_q, err_q;

  assign ready = (state_q == ST_RUN);

  // ---------------- init sweep FSM ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == SW'(SETS - 1)) state_d = ST_RUN;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      ST_RUN:  ;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- read, op select, update ----------------
  always_comb begin
    cur_row = '0;
    for (int s = 0; s < SETS; s++) begin
      if (i_set_idx == SW'(s)) cur_row = mem_q[s];
    end
  end

  always_comb begin
    op     = OP_NONE;
    op_way = '0;
    if (ready && i_lru_write_enable) begin
      if (i_inv_sig) begin
        op     = OP_INV;
        op_way = i_inv_way;
      end else if (i_hit_sig) begin
        op     = OP_HIT;
        op_way = i_hit_way;
      end else if (i_fill_sig) begin
        op = OP_FILL;
      end
    end
  end

  lru_rank_update #(.WAYS(WAYS)) u_update (
    .row_i    (cur_row),
    .op_i     (op),
    .way_i    (op_way),
    .row_o    (upd_row),
    .victim_o (upd_victim),
    .err_o    (upd_err)
  );

  // upd_row equals cur_row on error, so writing it back is harmless.
  always_ff @(posedge clk) begin
    for (int s = 0; s < SETS; s++) begin
      if (state_q == ST_INIT) begin
        if (cnt_q == SW'(s)) mem_q[s] <= DEF_ROW;
      end else if (op != OP_NONE && i_set_idx == SW'(s)) begin
        mem_q[s] <= upd_row;
      end
    end
  end

  // ---------------- output registers ----------------
  // Outputs show the post-write row: the op result, or the default row when
  // the sweep is writing the addressed set this cycle.
  assign init_hit = (state_q == ST_INIT) && (cnt_q == i_set_idx);
  assign rank_d   = init_hit ? DEF_ROW : upd_row;
  assign victim_d = init_hit ? DEF_VIC : upd_victim;

  always_ff @(posedge clk) begin
    if (rst) begin
      rank_q   <= '0;
      victim_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rank_q   <= rank_d;
      victim_q <= victim_d;
      valid_q  <= ready;
      err_q    <= upd_err;
    end
  end

  assign o_ready        = ready;
  assign o_rank         = rank_q;
  assign o_victim_way   = victim_q;
  assign o_victim_valid = valid_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_lru_set_array.sv
module tb_lru_set_array;

  localparam int WAYS = 8;
  localparam int SETS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  set_idx = '0;
  logic        we = 1'b0, hit = 1'b0, fill = 1'b0, inv = 1'b0;
  logic [7:0]  hit_way = '0, inv_way = '0;
  logic        ready, victim_valid, err;
  logic [7:0]  victim_way;
  logic [23:0] rank;

  lru_set_array #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_set_idx          (set_idx),
    .i_lru_write_enable (we),
    .i_hit_sig          (hit),
    .i_hit_way          (hit_way),
    .i_fill_sig         (fill),
    .i_inv_sig          (inv),
    .i_inv_way          (inv_way),
    .o_ready            (ready),
    .o_victim_way       (victim_way),
    .o_victim_valid     (victim_valid),
    .o_rank             (rank),
    .o_err              (err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [23:0] mk(input int r0, r1, r2, r3, r4, r5, r6, r7);
    logic [2:0] a [8];
    logic [23:0] v;
    a[0] = 3'(r0); a[1] = 3'(r1); a[2] = 3'(r2); a[3] = 3'(r3);
    a[4] = 3'(r4); a[5] = 3'(r5); a[6] = 3'(r6); a[7] = 3'(r7);
    v = '0;
    for (int k = 0; k < 8; k++) v[k*3 +: 3] = a[k];
    return v;
  endfunction

  function automatic logic is_perm(input logic [23:0] v);
    int seen [8];
    for (int k = 0; k < 8; k++) seen[k] = 0;
    for (int k = 0; k < 8; k++) seen[v[k*3 +: 3]]++;
    for (int k = 0; k < 8; k++) if (seen[k] != 1) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] s, input logic w, input logic h,
                       input logic [7:0] hw, input logic f, input logic iv,
                       input logic [7:0] iw);
    @(negedge clk);
    set_idx = s; we = w; hit = h; hit_way = hw; fill = f; inv = iv; inv_way = iw;
    @(posedge clk);
    #1;
  endtask

  task automatic read_set(input logic [1:0] s);
    drive(s, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_row(input string tag, input logic [23:0] exp_rank,
                           input logic [7:0] exp_vic);
    check({tag, "_rank"}, 32'(rank), 32'(exp_rank));
    check({tag, "_victim"}, 32'(victim_way), 32'(exp_vic));
    check({tag, "_valid"}, 32'(victim_valid), 32'd1);
    check({tag, "_perm"}, 32'(is_perm(rank)), 32'd1);
  endtask

  // Drop reset and count rising edges until o_ready is seen high.
  task automatic release_and_time(input string tag);
    int n;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) break;
    end
    check(tag, 32'(n), 32'(SETS));
  endtask

  logic [23:0] def_row;

  initial begin
    def_row = mk(0, 1, 2, 3, 4, 5, 6, 7);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_valid", 32'(victim_valid), 32'd0);
    check("rst_victim", 32'(victim_way), 32'd0);
    check("rst_rank", 32'(rank), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    release_and_time("ready_latency");
    for (int s = 0; s < SETS; s++) begin
      read_set(2'(s));
      check_row($sformatf("init_set%0d", s), def_row, 8'h80);
    end

    // three hits on set 2, back to back
    drive(2'd2, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 8'h00);
    check_row("hit_w5", mk(1, 2, 3, 4, 5, 0, 6, 7), 8'h80);
    drive(2'd2, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00);
    check_row("hit_w0", mk(0, 2, 3, 4, 5, 1, 6, 7), 8'h80);
    drive(2'd2, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 8'h00);
    check_row("hit_w2", mk(1, 3, 0, 4, 5, 2, 6, 7), 8'h80);
    read_set(2'd0); check_row("other_s0", def_row, 8'h80);
    read_set(2'd1); check_row("other_s1", def_row, 8'h80);
    read_set(2'd3); check_row("other_s3", def_row, 8'h80);
    read_set(2'd2); check_row("hold_s2", mk(1, 3, 0, 4, 5, 2, 6, 7), 8'h80);

    // invalidate then fill on set 2
    drive(2'd2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04);
    check_row("inv_w2", mk(0, 2, 7, 3, 4, 1, 5, 6), 8'h04);
    drive(2'd2, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check_row("fill", mk(1, 3, 0, 4, 5, 2, 6, 7), 8'h80);

    // inv beats hit in the same cycle
    drive(2'd0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01);
    check_row("prio_inv", mk(7, 0, 1, 2, 3, 4, 5, 6), 8'h01);
    // disabled write leaves the set alone
    drive(2'd0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8'h00);
    check_row("we_off", mk(7, 0, 1, 2, 3, 4, 5, 6), 8'h01);

    // non-one-hot way: error pulse, no change
    drive(2'd0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00);
    check("err_pulse", 32'(err), 32'd1);
    check_row("err_hold", mk(7, 0, 1, 2, 3, 4, 5, 6), 8'h01);
    read_set(2'd0);
    check("err_clear", 32'(err), 32'd0);
    drive(2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    check("err_inv_zero", 32'(err), 32'd1);
    check_row("err_inv_hold", mk(7, 0, 1, 2, 3, 4, 5, 6), 8'h01);
    read_set(2'd0);

    // reset in RUN after updates, then again mid-sweep
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rerun_ready", 32'(ready), 32'd0);
    check("rerun_rank", 32'(rank), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(victim_valid), 32'd0);
    release_and_time("ready_latency2");
    for (int s = 0; s < SETS; s++) begin
      read_set(2'(s));
      check_row($sformatf("resweep_set%0d", s), def_row, 8'h80);
    end

    // requests are ignored during the sweep
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_idx = 2'd3; we = 1'b1; hit = 1'b1; hit_way = 8'h80;
    repeat (SETS) @(posedge clk);
    #1;
    check("sweep_ready", 32'(ready), 32'd1);
    read_set(2'd3);
    check_row("sweep_ignore", def_row, 8'h80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lru_set_array.md
# lru_set_array

Parametrised true-LRU replacement state for a set-associative cache: holds a full rank vector for every way of every set, updates ranks on hit, fill and invalidate, and reports the victim way of the addressed set. It replaces the single-set 8-way LRU with a multi-set, any-power-of-two-way array that adds invalidate and fill operations, a victim output and a post-reset initialisation sweep. It sits between the tag-compare stage, which supplies the hit way and set index, and the refill controller, which consumes the victim.

## Interface
- WAYS, 8, associativity; power of two, 2..16
- SETS, 16, number of sets; power of two, 1..256
- RW, $clog2(WAYS), rank width (derived; not overridden)
- SW, max($clog2(SETS),1), set-index width (derived)
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- i_set_idx  in  SW  set addressed by this cycle's operation and victim lookup
- i_lru_write_enable  in  1  global update enable; 0 blocks all state changes
- i_hit_sig  in  1  hit update request
- i_hit_way  in  WAYS  one-hot hit way
- i_fill_sig  in  1  miss fill: promote current victim of i_set_idx to MRU
- i_inv_sig  in  1  invalidate request
- i_inv_way  in  WAYS  one-hot way to demote to LRU
- o_ready  out  1  1 once init sweep done; requests ignored while 0
- o_victim_way  out  WAYS  one-hot LRU way of addressed set (registered)
- o_victim_valid  out  1  o_victim_way valid this cycle
- o_rank  out  WAYS*RW  rank vector of addressed set, way k at [k*RW +: RW] (registered)
- o_err  out  1  one-cycle pulse: accepted request with non-one-hot way vector

## Operation
- Rank 0 = MRU, WAYS-1 = LRU; each set's ranks always a permutation of 0..WAYS-1.
- Default row: way k rank k.
- Request accepted in cycle t iff o_ready=1 and i_lru_write_enable=1 and any of inv/hit/fill asserted. Only one op applied per cycle; priority inv > hit > fill, lower ones dropped silently.
- Hit on way h (rank r): every way with rank < r increments; h becomes 0.
- Fill: identical to hit on the way whose rank is WAYS-1.
- Invalidate way v (rank r): every way with rank > r decrements; v becomes WAYS-1.
- Way vector not exactly one-hot on the selected op: no state change, o_err=1 at t+1.
- Init FSM states INIT, RUN. rst=1 -> INIT, sweep counter 0. INIT writes default row to set[counter] each cycle, counter+1; after row SETS-1 written -> RUN, o_ready=1. rst in RUN or mid-sweep restarts sweep from 0.
- Reset values: o_ready 0, o_victim_valid 0, o_victim_way 0, o_rank 0, o_err 0.

## Timing
- Lookup latency 1: i_set_idx sampled at edge ending cycle t; o_rank/o_victim_way for that set valid cycle t+1, o_victim_valid=1 iff o_ready was 1 in cycle t.
- Outputs reflect post-update state: an op accepted in cycle t on set s is visible in outputs at t+1 when cycle t addressed s (same-cycle forwarding; no read-before-write).
- Back-to-back ops on the same set every cycle are legal; each sees the previous result.
- o_ready first rises SETS cycles after the first cycle with rst=0.
- Memory is flops (SETS*WAYS*RW bits); no RAM macro.

## Structure
- Package lru_pkg: clog2-based RW/SW helpers, function onehot_ok(vec), function default_row(WAYS).
- Sub-module lru_rank_update: combinational; inputs current row, op code {NONE,HIT,FILL,INV}, way vector; outputs next row, victim one-hot, err flag. Top holds the array, init FSM and output registers.

## Test plan
- Reset, WAYS=8 SETS=4: o_ready=0 for 4 cycles after rst drops, then 1; o_rank of any set = ways 0..7 ranks 0..7, o_victim_way=8'h80.
- Set 2: hit 8'h20, 8'h01, 8'h04 consecutive cycles -> ranks w0..w7 = 1,3,0,4,5,2,6,7, victim 8'h80; sets 0,1,3 unchanged.
- Then inv 8'h04 on set 2 -> ranks 0,2,7,3,4,1,5,6, victim 8'h04; then fill -> way2 rank 0, victim 8'h80.
- Same cycle inv 8'h01 + hit 8'h02 on set 0 -> only inv applied: w0 rank 7, victim 8'h01; i_lru_write_enable=0 with hit -> no change.
- Hit with 8'h03 -> o_err pulse one cycle, rank vector unchanged; 10k random ops vs reference model, rank always a permutation.
- Assert rst mid-sweep and in RUN after updates -> sweep restarts, all sets return to default row, o_ready low exactly SETS cycles.
